mmm_serial: RTL and testbench
=============================

MMM_SERIAL -- requirements
Module: mmm_serial

Interface
REQ-001 Parameter W, default 8: modulus width in bits; iteration count is W+2.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rstb  in  1  asynchronous, active-low reset.
REQ-004 en  in  1  clock enable; when low, all state and outputs hold.
REQ-005 clr  in  1  synchronous abort, active-high, qualified by en.
REQ-006 start  in  1  request a multiplication; sampled only in IDLE with en=1.
REQ-007 a  in  W+1  operand A, required < 2M.
REQ-008 b  in  W+1  operand B, required < 2M.
REQ-009 m  in  W  modulus M, required odd.
REQ-010 busy  out  1  high while an accepted multiplication is in RUN.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  high with done when the request was rejected for even M.
REQ-013 r  out  W+1  result R = A*B*2^-(W+2) mod M, with R < 2M.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 IDLE, en=1, start=1, m[0]=1: a, b and m SHALL be latched, accumulator S and iteration counter cleared, busy=1, next state RUN.
REQ-016 IDLE, en=1, start=1, m[0]=0: no RUN; next state DONE with err=1 and r=0.
REQ-017 RUN iteration i (i = 0..W+1), one per enabled edge:
- q = S[0] xor (a_i and B[0])
- S <= (S + a_i*B + q*M) >> 1
REQ-018 S and the pre-shift sum SHALL be W+3 bits wide; no overflow is permitted.
REQ-019 A bits above W SHALL be treated as 0 for i = W+1.
REQ-020 On the edge completing iteration W+1: r <= final S[W:0], busy <= 0, err <= 0, next state DONE.
REQ-021 DONE SHALL last exactly one enabled cycle with done=1, then return to IDLE.
REQ-022 Latency from start-accept edge to done high SHALL be W+2 enabled edges; done SHALL be high in the cycle after the W+2th RUN edge.
REQ-023 start SHALL be ignored in RUN and DONE; a start in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back throughput of one result per W+4 cycles.
REQ-024 r SHALL hold its value from done until the next completed or rejected request; r SHALL NOT change during RUN.
REQ-025 clr=1 with en=1 in any state SHALL force IDLE with busy=0, done=0 and err=0; r SHALL be unchanged and no done SHALL be produced.
REQ-026 clr SHALL take priority over start on the same edge.
REQ-027 en=0 SHALL freeze the iteration counter, S and FSM state; a done pulse spanning en=0 cycles SHALL stay high until the next enabled edge.
REQ-028 Inputs a, b and m SHALL be ignored after acceptance; changing them during RUN SHALL NOT affect the result.

Reset
REQ-029 rstb low SHALL immediately force IDLE with busy=0, done=0, err=0, r=0, S=0 and counter=0, regardless of clk or en.
REQ-030 Reset assertion mid-RUN SHALL abort the operation with no done pulse.
REQ-031 After rstb deasserts, the first enabled edge with start=1 SHALL be accepted.

Verification
REQ-032 W=8, M=239, A=68, B=1, start for one cycle -> busy high for 10 cycles, then done=1 for exactly one cycle with r=1 and err=0.
REQ-033 M=239, A=0, B=200 -> done at 10 edges after accept with r=0; a start asserted during RUN is ignored, so there is only one done.
REQ-034 M=238 (even), start -> no busy; done=1 and err=1 on the next cycle; r=0.
REQ-035 Random odd M, A and B < 2M (include A=B=2M-1 and M=1), back-to-back starts:
- r compared against a reference model
- r < 2M
- r*2^10 congruent to A*B mod M
REQ-036 Mid-RUN disturbances, each in its own run:
- clr at RUN cycle 5 -> IDLE, no done, r unchanged
- rstb low at RUN cycle 5 -> all outputs 0
- en low for 3 cycles mid-RUN -> done delayed by exactly 3 cycles, r correct

Source files
------------

// File: rtl/mmm_serial.sv
// Bit-serial Montgomery multiplier: R = A*B*2^-(W+2) mod M, one bit of A per enabled cycle.
// Operands and result live in [0, 2M); the accumulator is W+3 bits so no iteration can overflow.
module mmm_serial #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         en,
    input  logic         clr,
    input  logic         start,
    input  logic [W:0]   a,
    input  logic [W:0]   b,
    input  logic [W-1:0] m,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W:0]   r
);
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] LAST = CW'(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W+2:0]  s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    r_q, r_d;
    logic          err_q, err_d;

    logic [W:0]    a_q, b_q;
    logic [W-1:0]  m_q;
    logic          load;

    logic [W:0]    a_sh;
    logic          a_bit;
    logic          q_bit;
    logic [W+2:0]  sum;
    logic [W+2:0]  s_next;

    // Shifting past the top of A yields zero, so iteration W+1 sees a_i = 0.
    assign a_sh   = a_q >> cnt_q;
    assign a_bit  = a_sh[0];
    assign q_bit  = s_q[0] ^ (a_bit & b_q[0]);
    assign sum    = s_q + (a_bit ? {2'b00, b_q} : '0) + (q_bit ? {3'b000, m_q} : '0);
    assign s_next = {1'b0, sum[W+2:1]};

    assign load = en && !clr && (state_q == IDLE) && start && m[0];

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        err_d   = err_q;
        if (en) begin
            if (clr) begin
                state_d = IDLE;
                err_d   = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (m[0]) begin
                                s_d     = '0;
                                cnt_d   = '0;
                                state_d = RUN;
                            end else begin
                                err_d   = 1'b1;
                                r_d     = '0;
                                state_d = DONE;
                            end
                        end
                    end
                    RUN: begin
                        s_d   = s_next;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            r_d     = s_next[W:0];
                            err_d   = 1'b0;
                            cnt_d   = '0;
                            state_d = DONE;
                        end
                    end
                    DONE: begin
                        err_d   = 1'b0;
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    // Operand copies are only consumed in RUN, after a load, so they need no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= a;
            b_q <= b;
            m_q <= m;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign err  = err_q;
    assign r    = r_q;

endmodule

// File: tb/tb_mmm_serial.sv
// Scoreboarded bench for mmm_serial: stimulus pushes expected results, a negedge monitor
// pops and compares them whenever done is consumed by an enabled edge.
module tb_mmm_serial;
    localparam int W = 8;
    localparam int N = W + 2;

    logic         clk = 1'b0;
    logic         rstb, en, clr, start;
    logic [W:0]   a, b;
    logic [W-1:0] m;
    logic         busy, done, err;
    logic [W:0]   r;

    always #5 clk = ~clk;

    mmm_serial #(.W(W)) dut (
        .clk(clk), .rstb(rstb), .en(en), .clr(clr), .start(start),
        .a(a), .b(b), .m(m),
        .busy(busy), .done(done), .err(err), .r(r)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     r;
        int     err;
        int     cyc;
        int     m;
        longint ab;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    int     r_hold = 0;
    int     first_seen = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Montgomery result from its definition: add the unique k*M (k < 2^N) that makes
    // A*B + k*M divisible by 2^N, then divide.
    function automatic int ref_mm(input int av, input int bv, input int mv);
        longint ab = longint'(av) * longint'(bv);
        for (int k = 0; k < (1 << N); k++) begin
            if (((ab + longint'(k) * mv) % (1 << N)) == 0)
                return int'((ab + longint'(k) * mv) >> N);
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rstb) begin
            first_seen = -1;
        end else if (done) begin
            if (first_seen < 0) first_seen = cyc;
            if (en) begin
                if (sb.size() == 0) begin
                    chk("done_without_request", done, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("r", r, mon_e.r);
                    chk("err", err, mon_e.err);
                    chk("done_latency", first_seen, mon_e.cyc);
                    if (mon_e.err == 0) begin
                        chk("r_below_2M", (int'(r) < 2 * mon_e.m), 1);
                        chk("r_congruent", (longint'(r) * (1 << N)) % mon_e.m, mon_e.ab % mon_e.m);
                    end
                    r_hold = mon_e.r;
                end
                first_seen = -1;
            end
        end
    end

    task automatic mult(input int av, input int bv, input int mv,
                        input int gap_at, input int gap_len, input bit start_mid);
        exp_t e;
        int   c;
        a = (W+1)'(av); b = (W+1)'(bv); m = W'(mv); start = 1'b1;
        @(posedge clk); #1;
        c = cyc;
        start = 1'b0;
        e.m  = mv;
        e.ab = longint'(av) * longint'(bv);
        if ((mv % 2) == 0) begin
            e.r = 0; e.err = 1; e.cyc = c;
            sb.push_back(e);
            chk("busy_reject", busy, 0);
            @(posedge clk); #1;
            chk("done_after_reject", done, 0);
            return;
        end
        e.r = ref_mm(av, bv, mv); e.err = 0;
        e.cyc = c + N + ((gap_at >= 0 && gap_at < N) ? gap_len : 0);
        sb.push_back(e);
        a = (W+1)'($urandom); b = (W+1)'($urandom); m = W'($urandom);
        for (int i = 0; i <= N; i++) begin
            chk("busy_run", busy, (i < N));
            if (i < N) chk("r_stable_run", r, r_hold);
            if (i == gap_at) begin
                en = 1'b0;
                repeat (gap_len) begin @(posedge clk); #1; end
                en = 1'b1;
            end
            start = start_mid && (i >= 3);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int mv, av, bv;
        rstb = 1'b0; en = 1'b1; clr = 1'b0; start = 1'b0;
        a = '0; b = '0; m = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_r", r, 0);
        #1 rstb = 1'b1;
        @(posedge clk); #1;

        mult(68, 1, 239, -1, 0, 1'b0);
        mult(0, 200, 239, -1, 0, 1'b1);
        mult(5, 9, 238, -1, 0, 1'b0);
        mult(477, 477, 239, -1, 0, 1'b0);
        mult(509, 509, 255, -1, 0, 1'b0);
        mult(1, 1, 1, -1, 0, 1'b0);
        mult(0, 1, 1, -1, 0, 1'b0);
        for (int t = 0; t < 40; t++) begin
            mv = 2 * int'($urandom_range(0, 127)) + 1;
            av = int'($urandom_range(0, 2 * mv - 1));
            bv = int'($urandom_range(0, 2 * mv - 1));
            mult(av, bv, mv, -1, 0, t[0]);
        end

        // clr at RUN cycle 5
        a = 9'd100; b = 9'd33; m = 8'd239; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_err", err, 0);
        chk("clr_r", r, r_hold);
        repeat (15) begin @(posedge clk); #1; end
        chk("clr_idle_busy", busy, 0);

        // clr beats start on the same edge
        clr = 1'b1; start = 1'b1; m = 8'd239;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        chk("clr_prio_busy", busy, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("clr_prio_done", done, 0);

        // reset at RUN cycle 5
        a = 9'd77; b = 9'd12; m = 8'd201; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rstb = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_r", r, 0);
        r_hold = 0;
        @(posedge clk);
        #2 rstb = 1'b1;
        mult(300, 150, 201, -1, 0, 1'b0);

        // enable gaps: during RUN, and while done is held
        mult(123, 45, 97, 4, 3, 1'b0);
        mult(180, 190, 97, N, 3, 1'b0);
        mult(5, 7, 238, -1, 0, 1'b0);
        mult(200, 201, 211, 7, 2, 1'b0);

        repeat (5) begin @(posedge clk); #1; end
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
